// File: rtl/totp_display_seq.sv
// totp_display_seq
// Takes a finished BCD code from the TOTP core over a valid/ready handshake,
// latches it, and shows it one digit at a time on the 7-segment lines.
// Each digit is followed by a blank gap, and the whole code is played
// REPEATS times before the sequencer returns to IDLE.
// seg/dp/pos/busy are registered; code_ready is combinational from
// state and clear so that a new code can be taken in the first idle cycle.

module totp_display_seq #(
  parameter int TICKS_PER_SLOT = 1000,
  parameter int GAP_TICKS      = 250,
  parameter int NUM_DIGITS     = 6,
  parameter int REPEATS        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    code_valid,
  output logic                    code_ready,
  input  logic [4*NUM_DIGITS-1:0] code,
  input  logic                    clear,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [2:0]              pos,
  output logic                    busy
);

  // Terminal values of the counters, cast once to the register widths.
  // When GAP_TICKS is 0 the GAP state is never entered, so GAP_LAST is unused.
  localparam logic [15:0] SLOT_LAST = 16'(TICKS_PER_SLOT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);
  localparam logic [2:0]  POS_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]  PASS_LAST = 4'(REPEATS - 1);
  localparam bit          NO_GAP    = (GAP_TICKS == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] code_q, code_d;
  logic [2:0]              pos_q, pos_d;
  logic [3:0]              pass_q, pass_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    busy_q, busy_d;
  logic                    accept_s;
  logic                    slot_end_s;

  // BCD value to segment pattern {g,f,e,d,c,b,a}; non-decimal values show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  // Select digit p of a code; digit 0 occupies the most significant nibble.
  function automatic logic [3:0] digit_at(input logic [4*NUM_DIGITS-1:0] c,
                                          input logic [2:0]              p);
    logic [3:0] d;
    d = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (p == 3'(i)) begin
        d = c[4*(NUM_DIGITS-1-i) +: 4];
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // A code can be taken only when idle and not being aborted in the same cycle.
  assign code_ready = (state_q == IDLE) && !clear;
  assign accept_s   = code_valid && code_ready;

  // Next-state logic: slot/gap timing, digit and pass stepping, clear override.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pos_d      = pos_q;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    slot_end_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          code_d  = code;
          pos_d   = 3'd0;
          pass_d  = 4'd0;
          cnt_d   = 16'd0;
          state_d = SHOW;
        end else begin
          pos_d   = 3'd0;
          cnt_d   = 16'd0;
        end
      end

      SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d = 16'd0;
          if (NO_GAP) begin
            // Without a gap the digit/pass advance happens straight from SHOW.
            slot_end_s = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d      = 16'd0;
          slot_end_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        pos_d   = 3'd0;
        pass_d  = 4'd0;
        cnt_d   = 16'd0;
      end
    endcase

    // End of a digit slot (gap finished, or show finished with no gap).
    if (slot_end_s) begin
      if (pos_q != POS_LAST) begin
        pos_d   = pos_q + 3'd1;
        state_d = SHOW;
      end else if (pass_q != PASS_LAST) begin
        pass_d  = pass_q + 4'd1;
        pos_d   = 3'd0;
        state_d = SHOW;
      end else begin
        pos_d   = 3'd0;
        pass_d  = 4'd0;
        state_d = IDLE;
      end
    end else begin
      pos_d = pos_d;
    end

    // Abort wins over everything, including a simultaneous accept.
    if (clear) begin
      state_d = IDLE;
      code_d  = code_q;
      pos_d   = 3'd0;
      pass_d  = 4'd0;
      cnt_d   = 16'd0;
    end else begin
      state_d = state_d;
    end
  end

  // Output values for the next cycle, derived from the next state so the
  // pins are registered yet change on the same edge as the state.
  always_comb begin
    seg_d  = 7'h00;
    dp_d   = 1'b0;
    busy_d = 1'b0;
    if (state_d == SHOW) begin
      seg_d  = seg_decode(digit_at(code_d, pos_d));
      dp_d   = (pos_d == 3'd0);
      busy_d = 1'b1;
    end else if (state_d == GAP) begin
      seg_d  = 7'h00;
      dp_d   = 1'b0;
      busy_d = 1'b1;
    end else begin
      seg_d  = 7'h00;
      dp_d   = 1'b0;
      busy_d = 1'b0;
    end
  end

  // State, latched code, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      pos_q   <= 3'd0;
      pass_q  <= 4'd0;
      cnt_q   <= 16'd0;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pos_q   <= pos_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      busy_q  <= busy_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign pos  = pos_q;
  assign busy = busy_q;

endmodule

// File: doc/totp_display_seq.md
# totp_display_seq

Display sequencer for the TOTP code path. It accepts a completed BCD code from the TOTP core over a valid/ready handshake, latches it, and plays the digits one at a time on the single 7-segment output. Each digit is followed by a blank gap, and the full code repeats a configurable number of times. It sits between the TOTP core and the `uo_out` pins and replaces the free-running digit counter as the owner of the segment lines.

## Interface
- `TICKS_PER_SLOT`, default 1000: clk cycles each digit is shown. Legal range 1..65535.
- `GAP_TICKS`, default 250: clk cycles of blank display after each digit. Legal range 0..65535; 0 means no gap.
- `NUM_DIGITS`, default 6: digits per code. Legal range 1..8.
- `REPEATS`, default 2: full passes over the code per accepted code. Legal range 1..15.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `code_valid`  in  1: TOTP core offers a code.
- `code_ready`  out  1: sequencer can accept a code.
- `code`  in  4*NUM_DIGITS: BCD digits. Digit 0, shown first, is `code[4*NUM_DIGITS-1 -: 4]`.
- `clear`  in  1: synchronous abort to IDLE.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active high.
- `dp`  out  1: decimal point. High while digit 0 is shown, marking the start of each pass.
- `pos`  out  3: index of the digit currently shown or gapped.
- `busy`  out  1: high in SHOW and GAP.

## Operation
- States: IDLE, SHOW, GAP.
  - Internal registers: latched code, `pos`, pass counter (4 bits), slot counter (16 bits).
- Decode, 4-bit value → `seg`:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - 10..15 = 0x40 (dash)
- `code_ready` = (state==IDLE) && !`clear`. This is combinational from state and `clear`.
- IDLE:
  - Outputs: `seg`=0, `dp`=0, `busy`=0, `pos`=0.
  - On `code_valid` && `code_ready`: latch `code`, set `pos`=0, pass=0, slot counter=0, go to SHOW.
- SHOW:
  - `seg` = decode(latched digit `pos`); `dp` = (`pos`==0).
  - Slot counter increments each cycle.
  - When the counter reaches TICKS_PER_SLOT-1: reset it to 0 and go to GAP. If GAP_TICKS==0, take the GAP exit actions directly instead.
- GAP:
  - `seg`=0, `dp`=0.
  - When the counter reaches GAP_TICKS-1, reset it to 0, then:
    - if `pos`<NUM_DIGITS-1: `pos`++, go to SHOW;
    - else if pass<REPEATS-1: pass++, `pos`=0, go to SHOW;
    - else go to IDLE.
- `clear`: in any state, the next state is IDLE and counters zero. It overrides a simultaneous accept; no code is latched.
- `code_valid` while busy is ignored. The core must hold `code`/`code_valid` until the handshake.
- The latched code is stable for the whole sequence; changes on `code` during busy have no effect.
- Reset: state IDLE. All counters and the latched code are 0. `seg`=0, `dp`=0, `pos`=0, `busy`=0, and therefore `code_ready`=1.

## Timing
- All outputs except `code_ready` are registered.
- Handshake at edge k → `busy`=1 and `seg`=digit 0 from cycle k+1.
- Each SHOW lasts exactly TICKS_PER_SLOT cycles; each GAP lasts exactly GAP_TICKS cycles.
- Total busy duration = REPEATS × NUM_DIGITS × (TICKS_PER_SLOT + GAP_TICKS) cycles.
  - `code_ready` rises in the first cycle after the final gap.
  - A new code may be accepted in that same cycle.
- `clear` asserted at edge k → IDLE outputs from cycle k+1.
- With TICKS_PER_SLOT=1 the sequencer shows each digit for one cycle. Back-to-back SHOW with GAP_TICKS=0 must not skip or repeat any digit.

## Test plan
Parameters T=4, G=2, N=6, R=2 unless noted.
- **Reset:** hold `rst_n`=0 three cycles → `seg`=0, `dp`=0, `pos`=0, `busy`=0, `code_ready`=1.
- **Basic sequence:** accept `code`=0x123456.
  - `seg` reads 0x06×4, 0×2, 0x5B×4, 0×2, … through 0x7D, then repeats once.
  - `dp` is high only during the two digit-0 slots.
  - `busy` lasts 72 cycles, then `code_ready`=1.
- **Busy / invalid digits:** hold `code_valid` during busy with a different `code` → ignored, sequence unchanged. Separately, accept 0xA00000 → first slot shows 0x40.
- **Clear:** pulse `clear` mid-GAP of digit 3 → IDLE next cycle, `seg`=0. Then `clear`=1 together with `code_valid`=1 in IDLE → no accept, `busy` stays 0.
- **No gap:** G=0, R=1, `code`=0x987654 → 24 contiguous non-blank cycles, `pos` steps 0..5 every 4 cycles.
- **Back-to-back:** keep `code_valid` asserted with the next code → accepted in the first cycle `code_ready` rises. Digit 0 of the new code appears the following cycle with no idle gap.
